z80_dma_master: RTL and testbench

//  Bus-initiator DMA engine for nano-z80 block transfers between RAM and the I/O window 0x80-0xFF.

---
 rtl/z80_bus_pkg.sv | 37 +++
 rtl/dma_bus_cycle.sv | 89 ++++++++
 rtl/z80_dma_master.sv | 200 ++++++++++++++++++++
 tb/tb_z80_dma_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
// Shared definitions for the nano-z80 DMA master: register map, FSM states,
// control bit positions and the I/O window address helper.
package z80_bus_pkg;

  localparam logic [7:0] REG_MADDR_L  = 8'h78;
  localparam logic [7:0] REG_MADDR_H  = 8'h79;
  localparam logic [7:0] REG_PORT_OFS = 8'h7A;
  localparam logic [7:0] REG_LEN      = 8'h7B;
  localparam logic [7:0] REG_CTRL     = 8'h7C;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;

  localparam logic [7:0] IO_WIN_BASE_DEF = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RD_SETUP,
    ST_RD_STB,
    ST_WR_SETUP,
    ST_WR_STB,
    ST_RELEASE
  } dma_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STB
  } cyc_phase_e;

  // Port addresses live in page 0; the window base supplies the high bit(s).
  function automatic logic [15:0] io_addr(input logic [7:0] base, input logic [6:0] ofs);
    return {8'h00, base | {1'b0, ofs}};
  endfunction

endpackage

// File: rtl/dma_bus_cycle.sv
// One Z80-style bus access: a single setup clock with strobes high, then
// STROBE_CYCLES clocks with the read or write strobe and its request low.
module dma_bus_cycle
  import z80_bus_pkg::*;
#(
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        i_start,
  input  logic        i_is_io,
  input  logic        i_is_wr,
  input  logic [15:0] i_addr,
  output logic [15:0] o_addr,
  output logic        o_mreq_n,
  output logic        o_ioreq_n,
  output logic        o_rd_n,
  output logic        o_wr_n,
  output logic        o_last
);

  localparam logic [2:0] LAST_CNT = 3'(STROBE_CYCLES - 1);

  cyc_phase_e  r_phase;
  logic [2:0]  r_cnt;
  logic        r_is_io;
  logic        r_is_wr;
  logic [15:0] r_addr;
  logic        r_mreq_n;
  logic        r_ioreq_n;
  logic        r_rd_n;
  logic        r_wr_n;

  assign o_last    = (r_phase == PH_STB) && (r_cnt == LAST_CNT);
  assign o_addr    = r_addr;
  assign o_mreq_n  = r_mreq_n;
  assign o_ioreq_n = r_ioreq_n;
  assign o_rd_n    = r_rd_n;
  assign o_wr_n    = r_wr_n;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_phase   <= PH_IDLE;
      r_cnt     <= 3'd0;
      r_is_io   <= 1'b0;
      r_is_wr   <= 1'b0;
      r_addr    <= 16'h0000;
      r_mreq_n  <= 1'b1;
      r_ioreq_n <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
    end else if (i_start) begin
      // A new access may begin on the same edge the previous strobe ends.
      r_phase   <= PH_SETUP;
      r_cnt     <= 3'd0;
      r_is_io   <= i_is_io;
      r_is_wr   <= i_is_wr;
      r_addr    <= i_addr;
      r_mreq_n  <= 1'b1;
      r_ioreq_n <= 1'b1;
      r_rd_n    <= 1'b1;
      r_wr_n    <= 1'b1;
    end else begin
      case (r_phase)
        PH_SETUP: begin
          r_phase   <= PH_STB;
          r_cnt     <= 3'd0;
          r_mreq_n  <= r_is_io;
          r_ioreq_n <= ~r_is_io;
          r_rd_n    <= r_is_wr;
          r_wr_n    <= ~r_is_wr;
        end
        PH_STB: begin
          if (o_last) begin
            r_phase   <= PH_IDLE;
            r_mreq_n  <= 1'b1;
            r_ioreq_n <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/z80_dma_master.sv
// Bus-initiator DMA engine: moves a block between RAM and the 128-port I/O
// window after taking the Z80 bus with BUSREQ/BUSACK.
module z80_dma_master
  import z80_bus_pkg::*;
#(
  parameter int         STROBE_CYCLES = 2,
  parameter logic [7:0] IO_WIN_BASE   = IO_WIN_BASE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        reg_cs_i,
  input  logic        reg_wr_n_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [7:0]  reg_data_i,
  output logic [7:0]  reg_data_o,
  output logic        busreq_n_o,
  input  logic        busack_n_i,
  output logic        m_oe_o,
  output logic [15:0] m_addr_o,
  output logic [7:0]  m_data_o,
  input  logic [7:0]  m_data_i,
  output logic        m_mreq_n_o,
  output logic        m_ioreq_n_o,
  output logic        m_rd_n_o,
  output logic        m_wr_n_o,
  output logic        done_o
);

  dma_state_e  r_state;
  logic [15:0] r_maddr;
  logic [6:0]  r_ofs;
  logic [7:0]  r_len;
  logic        r_dir;
  logic        r_done_flag;
  logic [15:0] r_ram_ptr;
  logic [6:0]  r_ofs_ptr;
  logic [7:0]  r_remain;
  logic        r_busreq_n;
  logic        r_oe;
  logic [7:0]  r_wdata;
  logic        r_done;

  logic        w_busy;
  logic        w_reg_we;
  logic        w_last;
  logic        w_cyc_start;
  logic        w_cyc_is_io;
  logic        w_cyc_is_wr;
  logic [15:0] w_cyc_addr;
  logic [15:0] w_bus_addr;
  logic [15:0] w_io_cur;
  logic [15:0] w_io_nxt;
  logic [15:0] w_ram_nxt;
  logic [7:0]  w_rdata;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_reg_we  = reg_cs_i & ~reg_wr_n_i;
  assign w_io_cur  = io_addr(IO_WIN_BASE, r_ofs_ptr);
  assign w_io_nxt  = io_addr(IO_WIN_BASE, r_ofs_ptr + 7'd1);
  assign w_ram_nxt = r_ram_ptr + 16'd1;

  // Pick which access the bus-cycle sequencer launches on this edge.
  always_comb begin
    w_cyc_start = 1'b0;
    w_cyc_is_io = r_dir;
    w_cyc_is_wr = 1'b0;
    w_cyc_addr  = r_dir ? w_io_cur : r_ram_ptr;
    case (r_state)
      ST_REQ: w_cyc_start = ~busack_n_i;
      ST_RD_STB: begin
        w_cyc_start = w_last;
        w_cyc_is_io = ~r_dir;
        w_cyc_is_wr = 1'b1;
        w_cyc_addr  = r_dir ? r_ram_ptr : w_io_cur;
      end
      ST_WR_STB: begin
        w_cyc_start = w_last && (r_remain > 8'd1);
        w_cyc_addr  = r_dir ? w_io_nxt : w_ram_nxt;
      end
      default: ;
    endcase
  end

  dma_bus_cycle #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_cycle (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .i_start  (w_cyc_start),
    .i_is_io  (w_cyc_is_io),
    .i_is_wr  (w_cyc_is_wr),
    .i_addr   (w_cyc_addr),
    .o_addr   (w_bus_addr),
    .o_mreq_n (m_mreq_n_o),
    .o_ioreq_n(m_ioreq_n_o),
    .o_rd_n   (m_rd_n_o),
    .o_wr_n   (m_wr_n_o),
    .o_last   (w_last)
  );

  assign m_oe_o     = r_oe;
  assign m_addr_o   = r_oe ? w_bus_addr : 16'h0000;
  assign m_data_o   = r_wdata;
  assign busreq_n_o = r_busreq_n;
  assign done_o     = r_done;
  assign reg_data_o = w_rdata;

  always_comb begin
    w_rdata = 8'h00;
    if (reg_cs_i) begin
      case (reg_addr_i)
        REG_MADDR_L:  w_rdata = r_maddr[7:0];
        REG_MADDR_H:  w_rdata = r_maddr[15:8];
        REG_PORT_OFS: w_rdata = {1'b0, r_ofs};
        REG_LEN:      w_rdata = r_len;
        REG_CTRL:     w_rdata = {w_busy, r_done_flag, 4'b0000, r_dir, 1'b0};
        default:      w_rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_maddr     <= 16'h0000;
      r_ofs       <= 7'd0;
      r_len       <= 8'd0;
      r_dir       <= 1'b0;
      r_done_flag <= 1'b0;
      r_ram_ptr   <= 16'h0000;
      r_ofs_ptr   <= 7'd0;
      r_remain    <= 8'd0;
      r_busreq_n  <= 1'b1;
      r_oe        <= 1'b0;
      r_wdata     <= 8'h00;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // Registers are only writable while idle, which also blocks START.
        ST_IDLE: begin
          if (w_reg_we) begin
            case (reg_addr_i)
              REG_MADDR_L:  r_maddr[7:0]  <= reg_data_i;
              REG_MADDR_H:  r_maddr[15:8] <= reg_data_i;
              REG_PORT_OFS: r_ofs         <= reg_data_i[6:0];
              REG_LEN:      r_len         <= reg_data_i;
              REG_CTRL: begin
                r_dir <= reg_data_i[CTRL_DIR];
                if (reg_data_i[CTRL_START]) begin
                  r_done_flag <= 1'b0;
                  r_ram_ptr   <= r_maddr;
                  r_ofs_ptr   <= r_ofs;
                  r_remain    <= (r_len == 8'd0) ? 8'd128 : r_len;
                  r_busreq_n  <= 1'b0;
                  r_state     <= ST_REQ;
                end
              end
              default: ;
            endcase
          end
        end
        ST_REQ: begin
          if (!busack_n_i) begin
            r_oe    <= 1'b1;
            r_state <= ST_RD_SETUP;
          end
        end
        ST_RD_SETUP: r_state <= ST_RD_STB;
        ST_RD_STB: begin
          if (w_last) begin
            r_wdata <= m_data_i;
            r_state <= ST_WR_SETUP;
          end
        end
        ST_WR_SETUP: r_state <= ST_WR_STB;
        ST_WR_STB: begin
          if (w_last) begin
            if (r_remain > 8'd1) begin
              r_remain  <= r_remain - 8'd1;
              r_ram_ptr <= w_ram_nxt;
              r_ofs_ptr <= r_ofs_ptr + 7'd1;
              r_state   <= ST_RD_SETUP;
            end else begin
              r_oe        <= 1'b0;
              r_busreq_n  <= 1'b1;
              r_done      <= 1'b1;
              r_done_flag <= 1'b1;
              r_wdata     <= 8'h00;
              r_state     <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_dma_master.sv
// Scoreboard bench for z80_dma_master: a block-transfer model queues the
// expected bus accesses, a negedge monitor pops and compares them.
module tb_z80_dma_master;

  localparam int SC = 2;
  localparam logic [7:0] A_ML = 8'h78, A_MH = 8'h79, A_OFS = 8'h7A, A_LEN = 8'h7B, A_CTRL = 8'h7C;

  typedef struct {
    logic        wr;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  data;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_cs, reg_wr_n;
  logic [7:0]  reg_addr, reg_data;
  logic [7:0]  reg_data_o;
  logic        busreq_n_o, busack_n;
  logic        m_oe_o;
  logic [15:0] m_addr_o;
  logic [7:0]  m_data_o, m_data_i;
  logic        m_mreq_n_o, m_ioreq_n_o, m_rd_n_o, m_wr_n_o, done_o;

  int   checks = 0, failures = 0;
  acc_t exp_q[$];
  int   ack_delay = 0, wcnt = 0;
  logic [7:0] mem_seed = 8'h00;
  int   grant_cyc = 0, wait_cyc = 0, wait_viol = 0, done_cnt = 0;
  int   acc_cnt = 0, wr_starts = 0, stb_len = 0;
  logic prev_idle = 1'b1;

  z80_dma_master #(.STROBE_CYCLES(SC), .IO_WIN_BASE(8'h80)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .reg_cs_i(reg_cs), .reg_wr_n_i(reg_wr_n), .reg_addr_i(reg_addr),
    .reg_data_i(reg_data), .reg_data_o(reg_data_o),
    .busreq_n_o(busreq_n_o), .busack_n_i(busack_n),
    .m_oe_o(m_oe_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_data_i(m_data_i),
    .m_mreq_n_o(m_mreq_n_o), .m_ioreq_n_o(m_ioreq_n_o),
    .m_rd_n_o(m_rd_n_o), .m_wr_n_o(m_wr_n_o), .done_o(done_o)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input logic io, input logic [7:0] s);
    logic [7:0] t;
    t = a[7:0] * 8'd29;
    return t ^ a[15:8] ^ s ^ (io ? 8'hC3 : 8'h00);
  endfunction

  // RAM and peripherals answer whatever location the DMA currently strobes.
  assign m_data_i = mem_byte(m_addr_o, ~m_ioreq_n_o, mem_seed);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // CPU grants the bus ack_delay clocks after seeing the request.
  initial begin
    busack_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (busreq_n_o) begin
        busack_n = 1'b1;
        wcnt = 0;
      end else if (busack_n) begin
        if (wcnt >= ack_delay) busack_n = 1'b0;
        else wcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stb_len = 0;
      prev_idle = 1'b1;
    end else begin
      if (!busreq_n_o && !busack_n) grant_cyc++;
      if (!busreq_n_o && busack_n) begin
        wait_cyc++;
        if (m_oe_o || !m_rd_n_o || !m_wr_n_o || !m_mreq_n_o || !m_ioreq_n_o) wait_viol++;
      end
      if (done_o) done_cnt++;
      if (!m_rd_n_o || !m_wr_n_o) begin
        stb_len++;
        if (prev_idle) begin
          acc_cnt++;
          if (!m_wr_n_o) wr_starts++;
          check("rd_wr_exclusive", {31'd0, !m_rd_n_o && !m_wr_n_o}, 32'd0);
          check("space_onehot", {31'd0, m_mreq_n_o ^ m_ioreq_n_o}, 32'd1);
          check("oe_during_strobe", {31'd0, m_oe_o}, 32'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_access", {16'd0, m_addr_o}, 32'hFFFF_FFFF);
          end else begin
            acc_t e;
            e = exp_q.pop_front();
            check("acc_dir_wr", {31'd0, !m_wr_n_o}, {31'd0, e.wr});
            check("acc_is_io", {31'd0, !m_ioreq_n_o}, {31'd0, e.io});
            check("acc_addr", {16'd0, m_addr_o}, {16'd0, e.addr});
            if (e.wr) check("acc_wdata", {24'd0, m_data_o}, {24'd0, e.data});
          end
        end
      end else if (stb_len > 0) begin
        check("strobe_width", stb_len, SC);
        stb_len = 0;
      end
      prev_idle = m_rd_n_o && m_wr_n_o;
    end
  end

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_cs = 1'b1; reg_wr_n = 1'b0; reg_addr = a; reg_data = d;
    @(negedge clk);
    reg_cs = 1'b0; reg_wr_n = 1'b1;
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    reg_cs = 1'b1; reg_wr_n = 1'b1; reg_addr = a;
    #1 v = reg_data_o;
    reg_cs = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] req);
    logic [7:0] v;
    read_reg(a, v);
    check(name, {24'd0, v}, {24'd0, req});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busreq_n"}, {31'd0, busreq_n_o}, 32'd1);
    check({tag, "_strobes_n"}, {28'd0, m_mreq_n_o, m_ioreq_n_o, m_rd_n_o, m_wr_n_o}, 32'hF);
    check({tag, "_oe"}, {31'd0, m_oe_o}, 32'd0);
    check({tag, "_addr"}, {16'd0, m_addr_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
  endtask

  int cur_len, cur_dir;

  task automatic start_xfer(input logic [15:0] maddr, input logic [6:0] ofs, input logic [7:0] len,
                            input logic dir, input int delay);
    acc_t  r, w;
    logic [15:0] ram, port;
    ack_delay = delay;
    mem_seed  = 8'($urandom);
    write_reg(A_ML, maddr[7:0]);
    write_reg(A_MH, maddr[15:8]);
    write_reg(A_OFS, {1'b0, ofs});
    write_reg(A_LEN, len);
    check_reg("rb_maddr_l", A_ML, maddr[7:0]);
    check_reg("rb_maddr_h", A_MH, maddr[15:8]);
    check_reg("rb_ofs", A_OFS, {1'b0, ofs});
    check_reg("rb_len", A_LEN, len);
    cur_len = (len == 8'd0) ? 128 : int'(len);
    cur_dir = int'(dir);
    for (int i = 0; i < cur_len; i++) begin
      ram  = 16'((int'(maddr) + i) % 65536);
      port = 16'(128 + ((int'(ofs) + i) % 128));
      r.wr = 1'b0; w.wr = 1'b1;
      r.data = 8'h00;
      if (!dir) begin
        r.io = 1'b0; r.addr = ram;
        w.io = 1'b1; w.addr = port; w.data = mem_byte(ram, 1'b0, mem_seed);
      end else begin
        r.io = 1'b1; r.addr = port;
        w.io = 1'b0; w.addr = ram; w.data = mem_byte(port, 1'b1, mem_seed);
      end
      exp_q.push_back(r);
      exp_q.push_back(w);
    end
    grant_cyc = 0; wait_cyc = 0; wait_viol = 0; done_cnt = 0;
    write_reg(A_CTRL, {6'd0, dir, 1'b1});
  endtask

  task automatic finish_xfer(input string tag);
    int t, budget;
    t = 0;
    budget = ack_delay + cur_len * 2 * (SC + 1) + 50;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk); #2;
      t++;
    end
    if (done_cnt == 0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_busreq_released"}, {31'd0, busreq_n_o}, 32'd1);
    check({tag, "_oe_released"}, {31'd0, m_oe_o}, 32'd0);
    check({tag, "_grant_clks"}, grant_cyc, cur_len * 2 * (SC + 1) + 1);
    check({tag, "_req_wait_clks"}, wait_cyc, ack_delay);
    check({tag, "_no_bus_before_grant"}, wait_viol, 32'd0);
    check({tag, "_all_accesses_seen"}, exp_q.size(), 32'd0);
    check_reg({tag, "_ctrl_after"}, A_CTRL, {2'b01, 4'b0000, cur_dir[0], 1'b0});
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] v;
    int t, target;
    rst_n = 1'b0; reg_cs = 1'b0; reg_wr_n = 1'b1; reg_addr = 8'h00; reg_data = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_wdata", {24'd0, m_data_o}, 32'd0);
    rst_n = 1'b1;
    for (int a = 8'h78; a <= 8'h7C; a++) check_reg("reset_reg", 8'(a), 8'h00);
    check_reg("unmapped_reg", 8'h77, 8'h00);

    // RAM -> IO, grant after 3 clocks
    start_xfer(16'h4000, 7'h00, 8'd4, 1'b0, 3);
    finish_xfer("t1");
    @(negedge clk); reg_cs = 1'b0; reg_addr = A_MH; #1;
    check("rdata_no_cs", {24'd0, reg_data_o}, 32'd0);

    // IO -> RAM with both pointers wrapping
    start_xfer(16'hFFFF, 7'h7E, 8'd3, 1'b1, 2);
    finish_xfer("t2");

    // LEN = 0 moves 128 bytes
    start_xfer(16'($urandom), 7'($urandom), 8'd0, 1'($urandom), 1);
    finish_xfer("t3");

    // register writes and START while busy are ignored
    start_xfer(16'h2100, 7'h05, 8'd5, 1'b0, 0);
    repeat (8) @(negedge clk);
    write_reg(A_ML, 8'hAA);
    write_reg(A_LEN, 8'h11);
    write_reg(A_CTRL, 8'h03);
    check_reg("busy_maddr_l", A_ML, 8'h00);
    check_reg("busy_len", A_LEN, 8'h05);
    check_reg("busy_ctrl", A_CTRL, 8'h80);
    finish_xfer("t4");
    repeat (20) @(negedge clk);
    check("t4_no_restart", {31'd0, busreq_n_o}, 32'd1);

    // long grant wait
    start_xfer(16'h8000, 7'h40, 8'd2, 1'b1, 50);
    finish_xfer("t5");

    // reset during the second write strobe
    start_xfer(16'h1234, 7'h10, 8'd4, 1'($urandom), 1);
    target = wr_starts + 2;
    t = 0;
    while (wr_starts < target && t < 500) begin
      @(negedge clk); #2;
      t++;
    end
    check("t6_reached_write2", {31'd0, wr_starts >= target}, 32'd1);
    check("t6_in_write_strobe", {31'd0, m_wr_n_o}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t6_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check_reg("t6_ctrl_idle", A_CTRL, 8'h00);
    check_reg("t6_maddr_cleared", A_ML, 8'h00);
    repeat (5) @(negedge clk);
    check("t6_stays_idle", {31'd0, busreq_n_o}, 32'd1);

    // randomized transfers
    for (int n = 0; n < 8; n++) begin
      start_xfer(16'($urandom), 7'($urandom), 8'($urandom_range(1, 12)), 1'($urandom),
                 int'($urandom_range(0, 6)));
      finish_xfer("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
